// File: rtl/alu_issue_queue_if.sv
// Dispatch, wakeup, availability and issue bundle of the ALU issue queue.
// The queue is the slave; the dispatch/CDB/ALU side is the master.
interface alu_issue_queue_if #(
  parameter int ENTRIES   = 8,
  parameter int N         = 2,
  parameter int NUM_FU    = 2,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 32
);
  localparam int CW = $clog2(ENTRIES + 1);

  logic                             squash;
  logic [N-1:0]                     dispatch_valid;
  logic [N-1:0][TAG_W-1:0]          dispatch_src1_tag;
  logic [N-1:0][TAG_W-1:0]          dispatch_src2_tag;
  logic [N-1:0][TAG_W-1:0]          dispatch_dest_tag;
  logic [N-1:0]                     dispatch_src1_ready;
  logic [N-1:0]                     dispatch_src2_ready;
  logic [N-1:0][PAYLOAD_W-1:0]      dispatch_payload;
  logic [CW-1:0]                    free_count;
  logic [N-1:0]                     cdb_valid;
  logic [N-1:0][TAG_W-1:0]          cdb_tag;
  logic [NUM_FU-1:0]                alu_avail;
  logic [NUM_FU-1:0]                issue_valid;
  logic [NUM_FU-1:0][TAG_W-1:0]     issue_src1_tag;
  logic [NUM_FU-1:0][TAG_W-1:0]     issue_src2_tag;
  logic [NUM_FU-1:0][TAG_W-1:0]     issue_dest_tag;
  logic [NUM_FU-1:0][PAYLOAD_W-1:0] issue_payload;

  modport master (
    output squash, dispatch_valid, dispatch_src1_tag, dispatch_src2_tag, dispatch_dest_tag,
           dispatch_src1_ready, dispatch_src2_ready, dispatch_payload, cdb_valid, cdb_tag, alu_avail,
    input  free_count, issue_valid, issue_src1_tag, issue_src2_tag, issue_dest_tag, issue_payload
  );

  modport slave (
    input  squash, dispatch_valid, dispatch_src1_tag, dispatch_src2_tag, dispatch_dest_tag,
           dispatch_src1_ready, dispatch_src2_ready, dispatch_payload, cdb_valid, cdb_tag, alu_avail,
    output free_count, issue_valid, issue_src1_tag, issue_src2_tag, issue_dest_tag, issue_payload
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Compacting out-of-order ALU issue queue: CDB wakeup, oldest-first select
// onto available FUs, registered issue outputs.

module alu_iq_wake #(
  parameter int N     = 2,
  parameter int TAG_W = 6
) (
  input  logic [TAG_W-1:0]        tag,
  input  logic                    rdy_i,
  input  logic [N-1:0]            cdb_valid,
  input  logic [N-1:0][TAG_W-1:0] cdb_tag,
  output logic                    rdy_o
);
  always_comb begin
    rdy_o = rdy_i;
    for (int j = 0; j < N; j++)
      if (cdb_valid[j] && cdb_tag[j] == tag) rdy_o = 1'b1;
  end
endmodule

module alu_issue_queue #(
  parameter int ENTRIES   = 8,
  parameter int N         = 2,
  parameter int NUM_FU    = 2,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 32
) (
  input logic              clock,
  input logic              reset,
  alu_issue_queue_if.slave io
);
  localparam int CW = $clog2(ENTRIES + 1);

  typedef struct packed {
    logic                 vld;
    logic [TAG_W-1:0]     s1_tag;
    logic                 s1_rdy;
    logic [TAG_W-1:0]     s2_tag;
    logic                 s2_rdy;
    logic [TAG_W-1:0]     dest;
    logic [PAYLOAD_W-1:0] payload;
  } slot_t;

  slot_t [ENTRIES-1:0]              slot_q, slot_d;
  logic  [ENTRIES-1:0]              s1_wk, s2_wk;
  logic  [N-1:0]                    d1_wk, d2_wk;
  logic  [CW-1:0]                   free_count_q, free_count_d;
  logic  [NUM_FU-1:0]               iss_vld_q, iss_vld_d;
  logic  [NUM_FU-1:0][TAG_W-1:0]    iss_s1_q, iss_s1_d, iss_s2_q, iss_s2_d, iss_dest_q, iss_dest_d;
  logic  [NUM_FU-1:0][PAYLOAD_W-1:0] iss_pl_q, iss_pl_d;

  // Wakeup applies to state at the edge only; select below ignores it.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_slot_wk
    alu_iq_wake #(.N(N), .TAG_W(TAG_W)) u_w1 (.tag(slot_q[i].s1_tag), .rdy_i(slot_q[i].s1_rdy),
      .cdb_valid(io.cdb_valid), .cdb_tag(io.cdb_tag), .rdy_o(s1_wk[i]));
    alu_iq_wake #(.N(N), .TAG_W(TAG_W)) u_w2 (.tag(slot_q[i].s2_tag), .rdy_i(slot_q[i].s2_rdy),
      .cdb_valid(io.cdb_valid), .cdb_tag(io.cdb_tag), .rdy_o(s2_wk[i]));
  end

  for (genvar l = 0; l < N; l++) begin : g_lane_wk
    alu_iq_wake #(.N(N), .TAG_W(TAG_W)) u_w1 (.tag(io.dispatch_src1_tag[l]), .rdy_i(io.dispatch_src1_ready[l]),
      .cdb_valid(io.cdb_valid), .cdb_tag(io.cdb_tag), .rdy_o(d1_wk[l]));
    alu_iq_wake #(.N(N), .TAG_W(TAG_W)) u_w2 (.tag(io.dispatch_src2_tag[l]), .rdy_i(io.dispatch_src2_ready[l]),
      .cdb_valid(io.cdb_valid), .cdb_tag(io.cdb_tag), .rdy_o(d2_wk[l]));
  end

  always_comb begin
    logic [ENTRIES-1:0] taken;
    logic               found;
    int                 cnt;
    slot_t              s;
    taken      = '0;
    found      = 1'b0;
    cnt        = 0;
    s          = '0;
    iss_vld_d  = '0;
    iss_s1_d   = iss_s1_q;
    iss_s2_d   = iss_s2_q;
    iss_dest_d = iss_dest_q;
    iss_pl_d   = iss_pl_q;
    slot_d     = '0;

    // Each available FU, in index order, takes the oldest eligible slot left.
    for (int k = 0; k < NUM_FU; k++) begin
      found = 1'b0;
      if (io.alu_avail[k]) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (!found && !taken[i] && slot_q[i].vld && slot_q[i].s1_rdy && slot_q[i].s2_rdy) begin
            found         = 1'b1;
            taken[i]      = 1'b1;
            iss_vld_d[k]  = 1'b1;
            iss_s1_d[k]   = slot_q[i].s1_tag;
            iss_s2_d[k]   = slot_q[i].s2_tag;
            iss_dest_d[k] = slot_q[i].dest;
            iss_pl_d[k]   = slot_q[i].payload;
          end
        end
      end
    end

    for (int i = 0; i < ENTRIES; i++) begin
      if (slot_q[i].vld && !taken[i]) begin
        s        = slot_q[i];
        s.s1_rdy = s1_wk[i];
        s.s2_rdy = s2_wk[i];
        for (int p = 0; p < ENTRIES; p++) if (p == cnt) slot_d[p] = s;
        cnt++;
      end
    end

    // Acceptance is gated by the registered free count, not by this cycle's issues.
    for (int l = 0; l < N; l++) begin
      if (io.dispatch_valid[l] && l < int'(free_count_q)) begin
        s.vld     = 1'b1;
        s.s1_tag  = io.dispatch_src1_tag[l];
        s.s1_rdy  = d1_wk[l];
        s.s2_tag  = io.dispatch_src2_tag[l];
        s.s2_rdy  = d2_wk[l];
        s.dest    = io.dispatch_dest_tag[l];
        s.payload = io.dispatch_payload[l];
        for (int p = 0; p < ENTRIES; p++) if (p == cnt) slot_d[p] = s;
        cnt++;
      end
    end

    free_count_d = CW'(ENTRIES - cnt);

    if (io.squash) begin
      slot_d       = '0;
      free_count_d = CW'(ENTRIES);
      iss_vld_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_q       <= '0;
      free_count_q <= CW'(ENTRIES);
      iss_vld_q    <= '0;
      iss_s1_q     <= '0;
      iss_s2_q     <= '0;
      iss_dest_q   <= '0;
      iss_pl_q     <= '0;
    end else begin
      slot_q       <= slot_d;
      free_count_q <= free_count_d;
      iss_vld_q    <= iss_vld_d;
      iss_s1_q     <= iss_s1_d;
      iss_s2_q     <= iss_s2_d;
      iss_dest_q   <= iss_dest_d;
      iss_pl_q     <= iss_pl_d;
    end
  end

  assign io.free_count     = free_count_q;
  assign io.issue_valid    = iss_vld_q;
  assign io.issue_src1_tag = iss_s1_q;
  assign io.issue_src2_tag = iss_s2_q;
  assign io.issue_dest_tag = iss_dest_q;
  assign io.issue_payload  = iss_pl_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: stimulus pushes expected issues,
// a negedge monitor pops and compares every presented issue.
module tb_alu_issue_queue;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int          fu;
    logic [5:0]  s1;
    logic [5:0]  d;
    logic [31:0] p;
    int          at;
  } exp_t;
  exp_t sb[$];

  alu_issue_queue_if #(.ENTRIES(8), .N(2), .NUM_FU(2), .TAG_W(6), .PAYLOAD_W(32)) io ();

  alu_issue_queue #(.ENTRIES(8), .N(2), .NUM_FU(2), .TAG_W(6), .PAYLOAD_W(32)) dut (
    .clock(clock), .reset(reset), .io(io.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        if (io.issue_valid[k]) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL spurious_issue fu=%0d dest=%0d cyc=%0d", k, io.issue_dest_tag[k], cyc);
          end else begin
            e = sb.pop_front();
            if (e.fu != k || e.d != io.issue_dest_tag[k] || e.s1 != io.issue_src1_tag[k] ||
                e.p != io.issue_payload[k] || e.at != cyc) begin
              failures++;
              $display("FAIL issue got fu=%0d dest=%0d s1=%0d pl=%0h cyc=%0d want fu=%0d dest=%0d s1=%0d pl=%0h cyc=%0d",
                       k, io.issue_dest_tag[k], io.issue_src1_tag[k], io.issue_payload[k], cyc,
                       e.fu, e.d, e.s1, e.p, e.at);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
    io.dispatch_valid = '0;
    io.cdb_valid      = '0;
    io.squash         = 1'b0;
  endtask

  task automatic disp(input int l, input logic [5:0] s1, input logic r1, input logic [5:0] s2,
                      input logic r2, input logic [5:0] d, input logic [31:0] p);
    io.dispatch_valid[l]      = 1'b1;
    io.dispatch_src1_tag[l]   = s1;
    io.dispatch_src1_ready[l] = r1;
    io.dispatch_src2_tag[l]   = s2;
    io.dispatch_src2_ready[l] = r2;
    io.dispatch_dest_tag[l]   = d;
    io.dispatch_payload[l]    = p;
  endtask

  task automatic bcast(input int l, input logic [5:0] t);
    io.cdb_valid[l] = 1'b1;
    io.cdb_tag[l]   = t;
  endtask

  task automatic push(input int fu, input logic [5:0] s1, input logic [5:0] d,
                      input logic [31:0] p, input int at);
    exp_t e;
    e.fu = fu; e.s1 = s1; e.d = d; e.p = p; e.at = at;
    sb.push_back(e);
  endtask

  initial begin
    int t;
    io.squash = 1'b0;
    io.dispatch_valid = '0;
    io.dispatch_src1_tag = '0;
    io.dispatch_src2_tag = '0;
    io.dispatch_dest_tag = '0;
    io.dispatch_src1_ready = '0;
    io.dispatch_src2_ready = '0;
    io.dispatch_payload = '0;
    io.cdb_valid = '0;
    io.cdb_tag = '0;
    io.alu_avail = 2'b11;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_free_count", int'(io.free_count), 8);
    chk("rst_issue_valid", int'(io.issue_valid), 0);
    chk("rst_dest_tags", int'(io.issue_dest_tag), 0);
    chk("rst_payload0", int'(io.issue_payload[0]), 0);
    reset = 1'b1;
    repeat (3) nxt();

    // Ready dispatch: issues two cycles later on FU 0
    t = cyc;
    disp(0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 32'h0000_00A5);
    push(0, 6'd1, 6'd5, 32'h0000_00A5, t + 2);
    nxt();
    chk("ready_fc_after_dispatch", int'(io.free_count), 7);
    nxt();
    chk("ready_fc_after_issue", int'(io.free_count), 8);
    repeat (2) nxt();

    // Wakeup and age: younger ready B goes first, A after tag 9 broadcast
    t = cyc;
    disp(0, 6'd9, 1'b0, 6'd1, 1'b1, 6'd20, 32'h0000_0200);
    push(0, 6'd2, 6'd21, 32'h0000_0201, t + 3);
    push(0, 6'd9, 6'd20, 32'h0000_0200, t + 5);
    nxt();
    disp(0, 6'd2, 1'b1, 6'd1, 1'b1, 6'd21, 32'h0000_0201);
    nxt();
    chk("wake_fc_two_waiting", int'(io.free_count), 6);
    nxt();
    bcast(0, 6'd9);
    repeat (4) nxt();

    // Same-cycle bypass on both lanes from cdb lane 1
    t = cyc;
    disp(0, 6'd3, 1'b1, 6'd12, 1'b0, 6'd30, 32'h0000_0300);
    disp(1, 6'd12, 1'b0, 6'd4, 1'b1, 6'd31, 32'h0000_0301);
    io.cdb_tag[0] = 6'd7;
    bcast(1, 6'd12);
    push(0, 6'd3, 6'd30, 32'h0000_0300, t + 2);
    push(1, 6'd12, 6'd31, 32'h0000_0301, t + 2);
    repeat (4) nxt();

    // Availability: only FU 1 free, then none, then both
    t = cyc;
    io.alu_avail = 2'b10;
    disp(0, 6'd10, 1'b1, 6'd11, 1'b1, 6'd40, 32'h0000_0400);
    disp(1, 6'd13, 1'b1, 6'd14, 1'b1, 6'd41, 32'h0000_0401);
    push(1, 6'd10, 6'd40, 32'h0000_0400, t + 2);
    push(0, 6'd13, 6'd41, 32'h0000_0401, t + 4);
    push(1, 6'd15, 6'd42, 32'h0000_0402, t + 4);
    nxt();
    disp(0, 6'd15, 1'b1, 6'd16, 1'b1, 6'd42, 32'h0000_0402);
    chk("avail_fc_two", int'(io.free_count), 6);
    nxt();
    io.alu_avail = 2'b00;
    chk("avail_fc_shift_append", int'(io.free_count), 6);
    nxt();
    io.alu_avail = 2'b11;
    chk("avail_fc_held", int'(io.free_count), 6);
    nxt();
    chk("avail_fc_drained", int'(io.free_count), 8);
    repeat (2) nxt();

    // Fill with waiting ops, partial acceptance, full drop, then squash
    for (int c = 0; c < 3; c++) begin
      disp(0, 6'(50 + 2 * c), 1'b0, 6'd1, 1'b1, 6'(20 + 2 * c), 32'h0000_0500 + c);
      disp(1, 6'(51 + 2 * c), 1'b0, 6'd1, 1'b1, 6'(21 + 2 * c), 32'h0000_0510 + c);
      nxt();
    end
    disp(0, 6'd56, 1'b0, 6'd1, 1'b1, 6'd26, 32'h0000_0520);
    nxt();
    chk("full_fc_one", int'(io.free_count), 1);
    disp(0, 6'd57, 1'b0, 6'd1, 1'b1, 6'd27, 32'h0000_0521);
    disp(1, 6'd58, 1'b0, 6'd1, 1'b1, 6'd28, 32'h0000_0522);
    nxt();
    chk("full_fc_zero", int'(io.free_count), 0);
    disp(0, 6'd1, 1'b1, 6'd1, 1'b1, 6'd33, 32'h0000_0530);
    disp(1, 6'd1, 1'b1, 6'd1, 1'b1, 6'd34, 32'h0000_0531);
    nxt();
    chk("full_drop_fc_zero", int'(io.free_count), 0);
    bcast(0, 6'd50);
    nxt();
    io.squash = 1'b1;
    disp(0, 6'd1, 1'b1, 6'd1, 1'b1, 6'd63, 32'h0000_0540);
    bcast(0, 6'd51);
    nxt();
    chk("squash_fc", int'(io.free_count), 8);
    chk("squash_issue_valid", int'(io.issue_valid), 0);
    for (int c = 0; c < 4; c++) begin
      bcast(0, 6'(52 + 2 * c));
      bcast(1, 6'(53 + 2 * c));
      nxt();
    end
    repeat (3) nxt();

    // Queue still works after squash
    t = cyc;
    disp(1, 6'd0, 1'b0, 6'd0, 1'b1, 6'd1, 32'h0000_0600);
    disp(0, 6'd8, 1'b1, 6'd8, 1'b1, 6'd2, 32'h0000_0601);
    push(0, 6'd8, 6'd2, 32'h0000_0601, t + 2);
    nxt();
    chk("post_squash_fc", int'(io.free_count), 6);
    bcast(0, 6'd0);
    push(0, 6'd0, 6'd1, 32'h0000_0600, t + 3);
    repeat (4) nxt();

    // Asynchronous reset mid-operation drops the queued op immediately
    disp(0, 6'd5, 1'b1, 6'd5, 1'b1, 6'd3, 32'h0000_0700);
    nxt();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_fc", int'(io.free_count), 8);
    chk("async_rst_issue_valid", int'(io.issue_valid), 0);
    #3 reset = 1'b1;
    repeat (4) nxt();

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
